// File: rtl/byte_serial_adder_seq.sv
// Multi-byte add/subtract sequencer driving one external 8-bit adder, LSB slice first.
// Operands arrive and results leave over valid/ready handshakes.
module byte_serial_adder_seq #(
    parameter  int unsigned NBYTES = 4,
    localparam int unsigned W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_ci,
    input  logic [7:0]   add_s,
    input  logic         add_co
);

    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic          carry;
    logic [IW-1:0] idx;
    logic          last_slice;

    // Operands shift out LSB-first with zero fill, so the adder inputs read
    // zero in IDLE and DONE without extra gating.
    assign add_a      = a_sh[7:0];
    assign add_b      = b_sh[7:0];
    assign add_ci     = carry;
    assign last_slice = (idx == IW'(NBYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= RUN;
                        in_ready <= 1'b0;
                        a_sh     <= op_a;
                        b_sh     <= op_b ^ {W{sub}};
                        carry    <= sub;
                        idx      <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned k = 0; k < NBYTES; k++) begin
                        if (idx == IW'(k)) begin
                            result[8*k +: 8] <= add_s;
                        end
                    end
                    a_sh <= a_sh >> 8;
                    b_sh <= b_sh >> 8;
                    idx  <= idx + IW'(1);
                    if (last_slice) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        carry     <= 1'b0;
                        carry_out <= add_co;
                        // top slice carries the sign bits of A, Beff and the result
                        overflow  <= (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
                    end else begin
                        carry <= add_co;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder_seq.sv
// Self-checking bench for byte_serial_adder_seq (NBYTES=4) with a behavioural
// 8-bit adder on the add_* port and a plain-arithmetic reference model.
module tb_byte_serial_adder_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_ci;
    logic [7:0]   add_s;
    logic         add_co;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] last_ci;
    logic [7:0] last_b0;

    byte_serial_adder_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co)
    );

    // External ripple-carry adder
    always_comb begin
        {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_ci};
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {overflow, carry_out, result} from signed/unsigned arithmetic
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      sa, sb, r;
        logic [32:0] u;
        logic [31:0] res;
        logic        co, ov;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = s ? sa - sb : sa + sb;
        ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        res = s ? a - b : a + b;
        if (s) begin
            co = (a >= b);
        end else begin
            u  = {1'b0, a} + {1'b0, b};
            co = u[32];
        end
        return {ov, co, res};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input logic noise, input string tag);
        logic [33:0] exp;
        logic [3:0]  ci;
        logic [7:0]  b0;
        int          n;
        exp = model(a, b, s);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_before"}, in_ready, 1);
        res_ready = (hold == 0);
        op_a = a;
        op_b = b;
        sub = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_ready_run"}, in_ready, 0);
        ci = '0;
        b0 = '0;
        n = 0;
        while (!res_valid && n < 20) begin
            if (n < 4) ci[n] = add_ci;
            if (n == 0) b0 = add_b;
            tick();
            n++;
        end
        last_ci = ci;
        last_b0 = b0;
        check({tag, "_latency"}, n, NB);
        check({tag, "_result"}, result, exp[31:0]);
        check({tag, "_carry"}, carry_out, exp[32]);
        check({tag, "_ovf"}, overflow, exp[33]);
        check({tag, "_adder_idle"}, {add_a, add_b, add_ci}, 0);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'b1;
                op_a = $urandom;
                op_b = $urandom;
            end
            tick();
            check({tag, "_hold_valid"}, {res_valid, in_ready}, 2'b10);
            check({tag, "_hold_out"}, {overflow, carry_out, result}, exp);
        end
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_idle_flags"}, {res_valid, in_ready}, 2'b01);
        check({tag, "_idle_held"}, {overflow, carry_out, result}, exp);
    endtask

    initial begin
        logic [33:0] e;
        logic [31:0] va[3];
        logic [31:0] vb[3];
        int          acc_t[3];
        int          acc, got;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_flags", {in_ready, res_valid}, 2'b10);
        check("rst_out", {overflow, carry_out, result}, 0);
        check("rst_adder", {add_a, add_b, add_ci}, 0);
        #10 rst_n = 1'b1;
        tick();

        // Basic add with carry ripple into slice 1
        do_op(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0, "add_ff_1");
        check("add_ff_1_ci_seq", last_ci, 4'b0010);
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, "add_wrap");
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, "add_ovf");

        // Subtract
        do_op(32'h00000005, 32'h00000007, 1'b1, 0, 1'b0, "sub_neg");
        check("sub_neg_first_b", last_b0, 8'hF8);
        check("sub_neg_first_ci", last_ci[0], 1'b1);
        do_op(32'h80000000, 32'h00000001, 1'b1, 0, 1'b0, "sub_ovf");

        // Back-pressure with ignored operands on the input port
        do_op(32'h01020304, 32'h10203040, 1'b0, 10, 1'b1, "backpressure");

        // Reset during the second RUN cycle
        op_a = 32'hDEADBEEF;
        op_b = 32'h01010101;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flags", {in_ready, res_valid}, 2'b10);
        check("midrst_out", {overflow, carry_out, result}, 0);
        check("midrst_adder", {add_a, add_b, add_ci}, 0);
        #3 rst_n = 1'b1;
        tick();
        check("midrst_after", {in_ready, res_valid}, 2'b10);
        do_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b0, "post_rst");

        // Back-to-back with in_valid held high
        va[0] = 32'h00000010; vb[0] = 32'h00000020;
        va[1] = 32'hFFFF0000; vb[1] = 32'h00010000;
        va[2] = 32'hAAAA5555; vb[2] = 32'h12345678;
        acc = 0;
        got = 0;
        acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
        res_ready = 1'b1;
        sub = 1'b0;
        op_a = va[0];
        op_b = vb[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            if (in_ready && in_valid) begin
                acc_t[acc] = cyc;
                acc++;
            end
            if (res_valid) begin
                e = model(va[got], vb[got], 1'b0);
                check("b2b_result", {overflow, carry_out, result}, e);
                check("b2b_ready_low", in_ready, 0);
                got++;
            end
            tick();
            if (acc < 3) begin
                op_a = va[acc];
                op_b = vb[acc];
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", got, 3);
        check("b2b_gap01", acc_t[1] - acc_t[0], NB + 2);
        check("b2b_gap12", acc_t[2] - acc_t[1], NB + 2);
        tick();
        tick();

        // Randomized operations with random back-pressure
        for (int i = 0; i < 25; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: rb = ra;
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
